// File: rtl/hack_mem_pkg.sv
// Shared types and default widths for the Hack data-RAM arbiter.
//   arb_state_t : arbiter mode (normal arbitration, halt pending, halted)
//   owner_t     : which port owns the read data returning next cycle
package hack_mem_pkg;

  localparam int unsigned HACK_ADDR_W = 15;
  localparam int unsigned HACK_DATA_W = 16;

  typedef enum logic [1:0] {
    RUN,
    HALT_PEND,
    HALTED
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DBG
  } owner_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating starvation counter for the debug port.
//   Clk    : clock, rising edge
//   Reset  : asynchronous, active-low reset
//   inc    : count one denied cycle (ignored once saturated)
//   clr    : clear to zero (takes priority over inc)
//   at_lim : counter has reached LIM
module arb_starve_cnt #(
  parameter int unsigned LIM = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic inc,
  input  logic clr,
  output logic at_lim
);

  localparam int unsigned CW = $clog2(LIM + 1);

  logic [CW-1:0] cnt;

  assign at_lim = (cnt == CW'(LIM));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_lim) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hack_ram_arbiter.sv
// Arbitrates the single-port Hack data RAM between the CPU data port and a
// debug/DMA port. CPU has priority; a starvation counter lets debug win one
// slot after STARVE_LIM consecutive denials; a halt handshake freezes the CPU
// and hands the RAM exclusively to debug.
//   Clk, Reset                       : clock / async active-low reset
//   cpu_req/we/addr/wdata            : CPU request
//   cpu_stall                        : CPU must hold request and PC
//   cpu_rvalid/rdata                 : CPU read return (1 cycle after grant)
//   dbg_req/we/addr/wdata            : debug request
//   dbg_gnt                          : debug request accepted this cycle
//   dbg_rvalid/rdata                 : debug read return
//   dbg_halt / dbg_halt_ack          : exclusive-ownership handshake
//   ram_addr/we/wdata, ram_rdata     : RAM port (1-cycle synchronous read)
module hack_ram_arbiter
  import hack_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = HACK_ADDR_W,
  parameter int unsigned DATA_W     = HACK_DATA_W,
  parameter int unsigned STARVE_LIM = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_halt,
  output logic              dbg_halt_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  arb_state_t state, state_nx;
  owner_t     owner;
  logic       ack_q;
  logic       at_lim;
  logic       cpu_win, dbg_win;

  // State register; ack is registered from the next state so it rises on
  // entry to HALTED and falls on the same edge that leaves it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= RUN;
      ack_q <= 1'b0;
    end else begin
      state <= state_nx;
      ack_q <= (state_nx == HALTED);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:       if (dbg_halt) state_nx = HALT_PEND;
      HALT_PEND: state_nx = dbg_halt ? HALTED : RUN;
      HALTED:    if (!dbg_halt) state_nx = RUN;
      default:   state_nx = RUN;
    endcase
  end

  // Grants are gated by the reset level so nothing reaches the RAM while
  // reset is held, even though the state flops are already cleared.
  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (Reset) begin
      if (state == RUN) begin
        if (dbg_req && (at_lim || !cpu_req)) dbg_win = 1'b1;
        else if (cpu_req)                     cpu_win = 1'b1;
      end else begin
        dbg_win = dbg_req;
      end
    end
    cpu_stall    = !Reset || (state != RUN) || (cpu_req && !cpu_win);
    dbg_gnt      = dbg_win;
    dbg_halt_ack = ack_q;
    ram_addr     = dbg_win ? dbg_addr  : cpu_addr;
    ram_wdata    = dbg_win ? dbg_wdata : cpu_wdata;
    ram_we       = (cpu_win && cpu_we) || (dbg_win && dbg_we);
  end

  // Read owner tag: steers the single returning read word to its requester.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      owner <= OWN_NONE;
    end else if (cpu_win && !cpu_we) begin
      owner <= OWN_CPU;
    end else if (dbg_win && !dbg_we) begin
      owner <= OWN_DBG;
    end else begin
      owner <= OWN_NONE;
    end
  end

  assign cpu_rvalid = (owner == OWN_CPU);
  assign dbg_rvalid = (owner == OWN_DBG);
  assign cpu_rdata  = ram_rdata;
  assign dbg_rdata  = ram_rdata;

  arb_starve_cnt #(
    .LIM (STARVE_LIM)
  ) u_starve (
    .Clk    (Clk),
    .Reset  (Reset),
    .inc    (dbg_req && !dbg_win),
    .clr    (!dbg_req || dbg_win || (state == HALTED)),
    .at_lim (at_lim)
  );

endmodule

// File: doc/hack_ram_arbiter.md
# hack_ram_arbiter

Shares the single-port Hack data RAM between the CPU data port and a debug/DMA port used by the bench and loader. The CPU has priority, a starvation counter guarantees the debug port forward progress, and a halt handshake lets the debug port own the RAM exclusively while the CPU is frozen. It sits between `cpu_inst` and the RAM in `cpu_garage`, replacing the direct `ram_address`/`we`/`cpu_out_m` hookup.

## Interface
- `ADDR_W`, 15, RAM word address width
- `DATA_W`, 16, data width
- `STARVE_LIM`, 3, consecutive denied debug cycles before debug wins one slot (≥1)

- `Clk`  in  1  clock, rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU accesses RAM this cycle
- `cpu_we`  in  1  CPU write (valid with `cpu_req`)
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data (`cpu_out_m`)
- `cpu_stall`  out  1  CPU must hold its request and PC this cycle
- `cpu_rvalid`  out  1  `cpu_rdata` valid
- `cpu_rdata`  out  DATA_W  CPU read data
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`  in  1/1/ADDR_W/DATA_W  debug request
- `dbg_gnt`  out  1  debug request accepted this cycle
- `dbg_rvalid`  out  1  `dbg_rdata` valid
- `dbg_rdata`  out  DATA_W  debug read data
- `dbg_halt`  in  1  level request for exclusive RAM ownership
- `dbg_halt_ack`  out  1  CPU frozen, debug owns RAM
- `ram_addr`, `ram_we`, `ram_wdata`  out  ADDR_W/1/DATA_W  RAM port
- `ram_rdata`  in  DATA_W  RAM read data, 1-cycle synchronous read

## Operation
- FSM `RUN`, `HALT_PEND`, `HALTED`; reset state `RUN`.
- `RUN` arbitration per cycle: if `starve_cnt == STARVE_LIM` and `dbg_req` → debug wins; else `cpu_req` → CPU wins; else `dbg_req` → debug wins.
- CPU loses while `cpu_req` → `cpu_stall=1`; CPU re-presents the same request next cycle.
- `starve_cnt`: +1 each cycle `dbg_req && !dbg_gnt`, saturates at `STARVE_LIM`, clears on `dbg_gnt` or `!dbg_req`.
- Winner's addr/we/wdata drive the RAM port combinationally. With no winner: `ram_we=0`, and `ram_addr`/`ram_wdata` hold the CPU values.
- The read owner tag is registered on every granted read (`!we`). The next cycle pulses the owner's `*_rvalid`, and `*_rdata = ram_rdata`. A write grant issues no rvalid.
- `RUN` with `dbg_halt=1` → `HALT_PEND`. This cycle's arbitration is unchanged.
- In `HALT_PEND`: `cpu_stall=1`; only debug is granted; the outstanding read return still completes. Next cycle → `HALTED` if `dbg_halt`, else `RUN`.
- In `HALTED`: `dbg_halt_ack=1` (registered), `cpu_stall=1`, `dbg_gnt = dbg_req` every cycle, `starve_cnt` held at 0. `dbg_halt=0` → `RUN` next cycle, ack drops the same edge.
- Reset low (async, any state): state `RUN`, `starve_cnt=0`, owner tag cleared, `*_rvalid=0`, `dbg_halt_ack=0`. While reset is held: `dbg_gnt=0`, `ram_we=0`, `cpu_stall=1`. An in-flight read is dropped and no rvalid follows.

## Timing
- Grant, `cpu_stall`, and RAM port: combinational, same cycle as the request.
- Read data latency: exactly 1 cycle after the grant; rvalid is a single-cycle pulse.
- Halt: `dbg_halt` rises in cycle N → `HALT_PEND` in N+1 → `dbg_halt_ack=1` in N+2. Release takes 1 cycle.
- Worst-case debug wait in `RUN` under continuous `cpu_req`: `STARVE_LIM`+1 cycles.

## Structure
- Package `hack_mem_pkg`: `arb_state_t` {RUN, HALT_PEND, HALTED}, `owner_t` {OWN_NONE, OWN_CPU, OWN_DBG}, and default `ADDR_W`/`DATA_W` constants.
- One sub-module, `arb_starve_cnt`: saturating counter with inc/clr inputs and an `at_lim` output.

## Test plan
- CPU-only read of `0x0010` (RAM holds `0xBEEF`) → `ram_addr=0x0010` same cycle; `cpu_rvalid=1`, `cpu_rdata=0xBEEF` next cycle; `cpu_stall=0` throughout.
- Continuous `cpu_req` with `dbg_req` write `0x0100←0x1234`, `STARVE_LIM=3` → debug denied 3 cycles, `dbg_gnt` in the 4th with `cpu_stall=1`, RAM `0x0100=0x1234`.
- Same-cycle CPU read `0x0005` and debug read `0x0006` with counter 0 → CPU served first; debug served the next cycle; each rvalid arrives only on its own port.
- `dbg_halt` during a CPU read → the CPU read still returns its rvalid; ack two cycles later; 5 back-to-back debug writes are all granted; drop `dbg_halt` → `RUN`, `cpu_stall=0` next cycle.
- Assert `Reset` low mid-halt while a debug read is in flight → ack, rvalid, and gnt all 0 immediately; after release, state is `RUN` and a CPU read of `0x0000` completes normally.
